// File: rtl/posit_pkg.sv
// posit_pkg: shared width helpers, scaling-factor limits and special posit codes for the encoder.
package posit_pkg;

    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
    } posit_flags_t;

    function automatic int scale_width(input int n, input int es);
        return es + $clog2(n) + 1;
    endfunction

    // Longest regime (run plus terminator) that can appear inside an n-bit word.
    function automatic int regime_width(input int n);
        return n;
    endfunction

    function automatic int frac_width(input int n);
        return n - 2;
    endfunction

    function automatic int maxsf(input int n, input int es);
        return (n - 2) * (1 << es);
    endfunction

    function automatic int minsf(input int n, input int es);
        return -maxsf(n, es);
    endfunction

    function automatic logic [63:0] nar_code(input int n);
        return 64'd1 << (n - 1);
    endfunction

    function automatic logic [63:0] zero_code(input int n);
        return (n > 0) ? 64'd0 : 64'd0;
    endfunction

    function automatic logic [63:0] maxpos_code(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] minpos_code(input int n);
        return (n > 1) ? 64'd1 : 64'd0;
    endfunction

endpackage

// File: rtl/posit_round.sv
// posit_round: rounds the (n-1)-bit posit magnitude and keeps it within [minpos, maxpos].
// Build option: POSIT_ENCODER_RNE_EN selects round-to-nearest-even; otherwise truncation.
module posit_round #(
    parameter int posit_width = 8
) (
    input  logic [posit_width-2:0] mag,
    input  logic                   guard,
    input  logic                   sticky,
    output logic [posit_width-2:0] mag_rnd
);
    import posit_pkg::*;

    localparam logic [63:0] MAXPOS_W = maxpos_code(posit_width);
    localparam logic [63:0] MINPOS_W = minpos_code(posit_width);

    logic                   round_up;
    logic [posit_width-1:0] sum;

`ifdef POSIT_ENCODER_RNE_EN
    assign round_up = guard & (sticky | mag[0]);
`else
    logic unused_round;
    assign unused_round = guard | sticky;
    assign round_up     = 1'b0;
`endif

    assign sum = {1'b0, mag} + {{(posit_width-1){1'b0}}, round_up};

    // A carry out of the magnitude would land on the NaR code, so it pins to maxpos.
    always_comb begin
        if (sum[posit_width-1]) begin
            mag_rnd = MAXPOS_W[posit_width-2:0];
        end else if (sum[posit_width-2:0] == '0) begin
            mag_rnd = MINPOS_W[posit_width-2:0];
        end else begin
            mag_rnd = sum[posit_width-2:0];
        end
    end

endmodule

// File: rtl/posit_encoder.sv
// posit_encoder: packs sign, scaling factor and fraction into an n-bit posit (2-stage pipeline).
// Build option: POSIT_ENCODER_RNE_EN selects round-to-nearest-even; default is truncation.
module posit_encoder #(
    parameter int  posit_width = 8,
    parameter int  es          = 1,
    localparam int scale_width = posit_pkg::scale_width(posit_width, es)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [scale_width-1:0] in_sf,
    input  logic [posit_width-1:0] in_frac,
    input  logic                   in_zero,
    input  logic                   in_exception,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [posit_width-1:0] posit_out
);
    import posit_pkg::*;

    localparam int MAG_W  = posit_width - 1;
    localparam int TAIL_W = es + frac_width(posit_width);
    localparam int STR_W  = regime_width(posit_width) + TAIL_W + 2;
    localparam int PAD_W  = STR_W - TAIL_W;

    localparam logic signed [scale_width-1:0] MAXSF = scale_width'(maxsf(posit_width, es));
    localparam logic signed [scale_width-1:0] MINSF = scale_width'(minsf(posit_width, es));

    localparam logic [63:0] NAR_W    = nar_code(posit_width);
    localparam logic [63:0] ZERO_W   = zero_code(posit_width);
    localparam logic [63:0] MAXPOS_W = maxpos_code(posit_width);
    localparam logic [63:0] MINPOS_W = minpos_code(posit_width);

    localparam logic [STR_W-1:0] TOP_ONE  = {1'b1, {(STR_W-1){1'b0}}};
    localparam logic [STR_W-1:0] ALL_ONES = '1;

    logic                          s1_valid;
    posit_flags_t                  s1_flags;
    logic [MAG_W-1:0]              s1_mag;
    logic                          s1_guard;
    logic                          s1_sticky;
    logic                          s2_valid;

    logic                          s1_adv;
    logic                          s2_adv;

    logic signed [scale_width-1:0] sf_s;
    logic signed [scale_width-1:0] k;
    logic [scale_width-1:0]        k_u;
    logic [scale_width-1:0]        rlen;
    logic [STR_W-1:0]              regime;
    logic [STR_W-1:0]              str;
    logic [MAG_W-1:0]              mag_c;
    logic                          guard_c;
    logic                          sticky_c;

    logic [MAG_W-1:0]              mag_rnd;
    logic [posit_width-1:0]        mag_full;
    logic [posit_width-1:0]        enc;

    logic                          unused_hidden;
    assign unused_hidden = in_frac[posit_width-1];

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: regime run, exponent and fraction laid out MSB-first; the word takes the top n-1 bits.
    always_comb begin
        sf_s     = $signed(in_sf);
        k        = sf_s >>> es;
        k_u      = k;
        rlen     = k[scale_width-1] ? (~k_u + scale_width'(2)) : (k_u + scale_width'(2));
        regime   = k[scale_width-1] ? (TOP_ONE >> (rlen - scale_width'(1)))
                                    : ~(ALL_ONES >> (rlen - scale_width'(1)));
        str      = regime | ({in_sf[es-1:0], in_frac[posit_width-2:1], {PAD_W{1'b0}}} >> rlen);
        mag_c    = str[STR_W-1 -: MAG_W];
        guard_c  = str[STR_W-posit_width];
        sticky_c = (|str[STR_W-posit_width-1:0]) | in_frac[0];
        if (sf_s > MAXSF) begin
            mag_c    = MAXPOS_W[MAG_W-1:0];
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end else if (sf_s < MINSF) begin
            mag_c    = MINPOS_W[MAG_W-1:0];
            guard_c  = 1'b0;
            sticky_c = 1'b0;
        end
    end

    posit_round #(
        .posit_width (posit_width)
    ) u_round (
        .mag     (s1_mag),
        .guard   (s1_guard),
        .sticky  (s1_sticky),
        .mag_rnd (mag_rnd)
    );

    // Stage 2: sign applied as two's complement of {0, magnitude}; NaR outranks zero.
    always_comb begin
        mag_full = {1'b0, mag_rnd};
        enc      = s1_flags.sign ? (~mag_full + posit_width'(1)) : mag_full;
        if (s1_flags.nar) begin
            enc = NAR_W[posit_width-1:0];
        end else if (s1_flags.zero) begin
            enc = ZERO_W[posit_width-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_flags  <= '0;
            s1_mag    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s2_valid  <= 1'b0;
            posit_out <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_flags.sign <= in_sign;
                    s1_flags.zero <= in_zero;
                    s1_flags.nar  <= in_exception;
                    s1_mag        <= mag_c;
                    s1_guard      <= guard_c;
                    s1_sticky     <= sticky_c;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    posit_out <= enc;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder: directed and randomized checks of posit_encoder (n=8, es=1) against a bit-string model.
module tb_posit_encoder;

`ifdef POSIT_ENCODER_RNE_EN
    localparam bit RNE_MODE = 1'b1;
`else
    localparam bit RNE_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sign = 1'b0;
    logic [4:0] in_sf = '0;
    logic [7:0] in_frac = '0;
    logic       in_zero = 1'b0;
    logic       in_exception = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] posit_out;

    int errors = 0;
    int checks = 0;

    posit_encoder #(.posit_width(8), .es(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_sf        (in_sf),
        .in_frac      (in_frac),
        .in_zero      (in_zero),
        .in_exception (in_exception),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .posit_out    (posit_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: append regime, exponent and fraction bits to an integer, then cut and round.
    function automatic logic [7:0] ref_encode(input bit sign, input int sf, input logic [7:0] frac,
                                              input bit zero, input bit exc);
        int     e, k, nb, mag, guard, sticky;
        bit     rne_up;
        longint bits;
        if (exc) return 8'h80;
        if (zero) return 8'h00;
        if (sf > 12) begin
            mag = 127;
        end else if (sf < -12) begin
            mag = 1;
        end else begin
            e    = ((sf % 2) + 2) % 2;
            k    = (sf - e) / 2;
            bits = 0;
            nb   = 0;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin bits = bits * 2 + 1; nb++; end
                bits = bits * 2; nb++;
            end else begin
                for (int i = 0; i < -k; i++) begin bits = bits * 2; nb++; end
                bits = bits * 2 + 1; nb++;
            end
            bits   = bits * 2 + e; nb++;
            bits   = bits * 64 + longint'(frac[6:1]); nb += 6;
            mag    = int'(bits >> (nb - 7));
            guard  = int'((bits >> (nb - 8)) & 1);
            sticky = (((bits & ((64'sd1 << (nb - 8)) - 1)) != 0) || frac[0]) ? 1 : 0;
            rne_up = (guard == 1) && (sticky == 1 || (mag % 2) == 1);
            if (RNE_MODE && rne_up) mag++;
            if (mag > 127) mag = 127;
            if (mag == 0) mag = 1;
        end
        if (sign) mag = 256 - mag;
        return mag[7:0];
    endfunction

    // Drives one beat with out_ready high and reports the result and accept-to-valid latency.
    task automatic do_beat(input bit sign, input int sf, input logic [7:0] frac, input bit zero,
                           input bit exc, output logic [7:0] res, output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        lat = 0;
        res = 'x;
        @(negedge clk);
        in_sign = sign; in_sf = 5'(sf); in_frac = frac;
        in_zero = zero; in_exception = exc;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!in_ready) return;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            lat++;
            #1;
            if (out_valid) begin res = posit_out; ok = 1'b1; return; end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (posit_out !== 8'h00) begin errors++; $display("FAIL reset_posit_out got %h want 00", posit_out); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_vectors;
        bit         sgn[15] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
        int         sfs[15] = '{0, 0, 3, 0, 0, 14, -14, -14, 0, 5, 0, -1, 11, -11, -11};
        logic [7:0] frc[15] = '{8'h80, 8'h80, 8'hC0, 8'h8C, 8'h84, 8'h80, 8'h80, 8'h80,
                                8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80, 8'h80};
        bit         zro[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        bit         exc[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        logic [7:0] ex_t[15] = '{8'h40, 8'hC0, 8'h6C, 8'h41, 8'h40, 8'h7F, 8'h01, 8'hFF,
                                 8'h80, 8'h80, 8'h00, 8'h30, 8'h7E, 8'h01, 8'hFF};
        logic [7:0] ex_r[15] = '{8'h40, 8'hC0, 8'h6C, 8'h42, 8'h40, 8'h7F, 8'h01, 8'hFF,
                                 8'h80, 8'h80, 8'h00, 8'h30, 8'h7F, 8'h02, 8'hFE};
        logic [7:0] res, exp;
        int         lat;
        bit         ok;
        for (int i = 0; i < 15; i++) begin
            do_beat(sgn[i], sfs[i], frc[i], zro[i], exc[i], res, lat, ok);
            exp = RNE_MODE ? ex_r[i] : ex_t[i];
            checks++;
            if (!ok) begin
                errors++; $display("FAIL vec%0d_timeout got no output want %h", i, exp);
            end else if (res !== exp) begin
                errors++; $display("FAIL vec%0d_value got %h want %h", i, res, exp);
            end
            checks++;
            if (ok && lat != 2) begin
                errors++; $display("FAIL vec%0d_latency got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        bit         sgn[3] = '{0, 0, 1};
        int         sfs[3] = '{0, 3, -1};
        logic [7:0] frc[3] = '{8'h80, 8'hC0, 8'h80};
        logic [7:0] exp[3];
        int         acc = 0, idx = 0, first_emit = -1, last_emit = -1;
        for (int i = 0; i < 3; i++) exp[i] = ref_encode(sgn[i], sfs[i], frc[i], 1'b0, 1'b0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid = (acc < 3);
            if (acc < 3) begin
                in_sign = sgn[acc]; in_sf = 5'(sfs[acc]); in_frac = frc[acc];
                in_zero = 1'b0; in_exception = 1'b0;
            end
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (acc != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", acc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1 || posit_out !== exp[0]) begin
            errors++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid, posit_out, exp[0]);
        end
        for (int c = 0; c < 10 && idx < 3; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'b1;
            in_valid = (acc < 3);
            if (acc < 3) begin
                in_sign = sgn[acc]; in_sf = 5'(sfs[acc]); in_frac = frc[acc];
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (posit_out !== exp[idx]) begin
                    errors++; $display("FAIL bp_order%0d got %h want %h", idx, posit_out, exp[idx]);
                end
                if (first_emit < 0) first_emit = c;
                last_emit = c;
                idx++;
            end
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 3 || last_emit - first_emit != 2) begin
            errors++; $display("FAIL bp_drain got %0d beats over %0d cycles want 3 over 2", idx, last_emit - first_emit);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        logic [7:0] exp, prev_out = '0, frac = '0;
        bit         prev_stall = 1'b0, pending = 1'b0, sign = 1'b0, zero = 1'b0, exc = 1'b0;
        int         sf = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!pending && $urandom_range(0, 9) < 7) begin
                sign = 1'($urandom_range(0, 1));
                sf   = int'($urandom_range(0, 31)) - 16;
                frac = 8'($urandom);
                zero = ($urandom_range(0, 15) == 0);
                exc  = ($urandom_range(0, 15) == 0);
                in_sign = sign; in_sf = 5'(sf); in_frac = frac;
                in_zero = zero; in_exception = exc;
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || posit_out !== prev_out) begin
                    errors++; $display("FAIL rnd_hold got v=%b %h want v=1 %h", out_valid, posit_out, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra got %h want no output", posit_out);
                end else begin
                    exp = q.pop_front();
                    if (posit_out !== exp) begin
                        errors++; $display("FAIL rnd_value got %h want %h", posit_out, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_encode(sign, sf, frac, zero, exc));
                pending = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = posit_out;
        end
        in_valid  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checks++;
                exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
                if (posit_out !== exp) begin
                    errors++; $display("FAIL rnd_drain got %h want %h", posit_out, exp);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", q.size()); end
    endtask

    task automatic test_reset_mid;
        int         stale = 0, lat;
        logic [7:0] res;
        bit         ok;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign = 1'b0; in_sf = 5'd3; in_frac = 8'hC0; in_zero = 1'b0; in_exception = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_prefill got %b want 1", out_valid); end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_flush got %b want 0", out_valid); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rm_stale got %0d outputs want 0", stale); end
        do_beat(1'b1, 0, 8'h80, 1'b0, 1'b0, res, lat, ok);
        checks++;
        if (!ok || res !== 8'hC0) begin errors++; $display("FAIL rm_after got %h want c0", res); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/posit_encoder.md
# posit_encoder

Packs the normalized result of the posit arithmetic operator (sign, scaling factor, hidden-bit-aligned fraction with sticky LSB, zero and exception flags) back into a standard n-bit posit word. It sits directly downstream of the arithmetic operator and is the inverse of the operand decoder. It is a 2-stage pipeline with valid/ready handshakes on both sides: regime/exponent construction in stage 1, rounding, saturation and two's-complement negation in stage 2.

## Interface
- posit_width, 8, posit size n
- es, 1, exponent field size
- scale_width (local), es + $clog2(posit_width) + 1, signed scaling-factor width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder accepts beat this cycle
- in_sign  in  1  result sign
- in_sf  in  scale_width  signed two's-complement scaling factor
- in_frac  in  posit_width  [n-1] hidden bit (ignored, taken as 1), [n-2:1] fraction, [0] sticky
- in_zero  in  1  result is zero
- in_exception  in  1  result is NaR
- out_valid  out  1  posit_out valid
- out_ready  in  1  downstream accepts
- posit_out  out  posit_width  encoded posit

## Operation
- Transfer on in_valid & in_ready; on out_valid & out_ready.
- Priority: in_exception → posit_out = 1 followed by n-1 zeros (0x80 for n=8). Else in_zero → all zeros. in_sign is ignored in both cases.
- Clamp: maxsf = (n-2)·2^es, minsf = -maxsf. If in_sf > maxsf → magnitude is maxpos (0 followed by n-1 ones). If in_sf < minsf → magnitude is minpos (n-1 zeros then 1).
- k = in_sf >>> es (arithmetic shift); e = in_sf[es-1:0].
- Regime: for k ≥ 0, k+1 ones then one 0. For k < 0, -k zeros then one 1.
- Build the bit string {regime, e, in_frac[n-2:1]}. Take the top n-1 bits as the magnitude.
- Guard = next bit. Sticky = OR of all remaining bits | in_frac[0].
- Rounding per the Configuration section.
- Rounded magnitude must never become 0 or reach the NaR code. If the round-up carries into bit n-1, the result is maxpos. A nonzero value never encodes to 0; it becomes at least minpos.
- If in_sign = 1: posit_out = two's complement of {0, magnitude}.

## Timing
- Latency is 2 cycles from input accept to out_valid, with no stall.
- Throughput is 1 beat per cycle.
- Stage 2 advances when s2_valid is 0 or out_ready is 1.
- Stage 1 advances when s1_valid is 0 or stage 2 advances.
- in_ready = stage-1 advance condition. It is combinational from registered state and out_ready.
- posit_out and out_valid must hold stable while out_valid = 1 and out_ready = 0.
- Reset: s1_valid, s2_valid, out_valid = 0; posit_out = 0; in_ready = 1 after reset. Reset asserted mid-operation flushes both stages and drops in-flight beats.
- Simultaneous accept and emit in the same cycle is legal; ordering is preserved.

## Configuration
- POSIT_ENCODER_RNE_EN defined: round to nearest, ties to even. Round up when guard & (sticky | lsb).
- Not defined: truncation toward zero on the magnitude; guard and sticky are ignored.
- Saturation and the never-zero rule apply in both modes.

## Structure
- Shared package posit_pkg holds:
  - width helpers (regime_width, scale_width, frac_width)
  - maxsf/minsf functions of (posit_width, es)
  - NaR/zero/maxpos/minpos constant functions
- One sub-module, posit_round: combinational. Inputs are magnitude, guard and sticky; outputs are the rounded, saturated magnitude. It holds the POSIT_ENCODER_RNE_EN logic.

## Test plan
All cases use n=8, es=1.
- sf=0, frac=0x80, sign=0 → 0x40. Same input with sign=1 → 0xC0.
- sf=3, frac=0xC0 (value 12) → 0x6C.
- Rounding, sf=0:
  - frac=0x8C → 0x42 with RNE, 0x41 without.
  - frac=0x84 → 0x40 in both modes (tie to even).
- Saturation:
  - sf=+14 → 0x7F.
  - sf=-14 → 0x01.
  - sf=-14 with sign=1 → 0xFF.
- exception=1 with zero=1, any sign → 0x80. zero=1 with sign=1 → 0x00.
- Backpressure and reset:
  - Hold out_ready=0 and stream 3 beats: in_ready drops after 2 accepts.
  - Release out_ready: outputs emerge in order, 1 per cycle.
  - Assert reset mid-stream: out_valid=0 the next cycle, and no stale output afterwards.
